// File: rtl/fft8_input_reorder.sv
// ---------------------------------------------------------------------------
// fft8_input_reorder
//
// Front end of the 8-point radix-2 DIT FFT. It collects one frame of eight
// complex samples in natural order, then presents the four stage-1
// butterfly operand pairs in bit-reversed pairing order: (0,4), (2,6),
// (1,5), (3,7). Samples pass through bit-exact.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    sample handshake (in_ready high only while filling)
//   in_r, in_i            signed sample real / imaginary parts
//   out_valid, out_ready  operand pair handshake (out_valid starts butterfly)
//   x1_r, x1_i            upper operand of the presented pair
//   x2_r, x2_i            lower operand of the presented pair
//   pair_idx              index 0..3 of the presented pair
//   frame_done            pulses on the handshake of pair 3
// ---------------------------------------------------------------------------
module fft8_input_reorder #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x1_r,
    output logic [DATA_W-1:0] x1_i,
    output logic [DATA_W-1:0] x2_r,
    output logic [DATA_W-1:0] x2_i,
    output logic [1:0]        pair_idx,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        FILL,
        PREP,
        DRAIN
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [1:0]        next_pair;
    logic [DATA_W-1:0] mem_r [8];
    logic [DATA_W-1:0] mem_i [8];

    // Pair p takes its upper operand from the 2-bit reversal of p and its
    // lower operand from the same address plus 4.
    function automatic logic [2:0] upper_addr(input logic [1:0] p);
        return {1'b0, p[0], p[1]};
    endfunction

    function automatic logic [2:0] lower_addr(input logic [1:0] p);
        return {1'b1, p[0], p[1]};
    endfunction

    assign in_ready   = (state == FILL);
    assign next_pair  = pair_idx + 2'd1;
    assign frame_done = out_valid & out_ready & (pair_idx == 2'd3);

    // Frame buffer: no reset, its contents are meaningless until refilled.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            mem_r[cnt] <= in_r;
            mem_i[cnt] <= in_i;
        end
    end

    // Control FSM with registered operand outputs. Pair 0 is loaded in the
    // single PREP cycle so the last sample write has already landed; later
    // pairs load on the handshake of the previous one, giving no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= 3'd0;
            pair_idx  <= 2'd0;
            out_valid <= 1'b0;
            x1_r      <= '0;
            x1_i      <= '0;
            x2_r      <= '0;
            x2_i      <= '0;
        end else begin
            case (state)
                FILL: begin
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        if (cnt == 3'd7) begin
                            cnt   <= 3'd0;
                            state <= PREP;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                PREP: begin
                    x1_r      <= mem_r[upper_addr(2'd0)];
                    x1_i      <= mem_i[upper_addr(2'd0)];
                    x2_r      <= mem_r[lower_addr(2'd0)];
                    x2_i      <= mem_i[lower_addr(2'd0)];
                    pair_idx  <= 2'd0;
                    out_valid <= 1'b1;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (pair_idx == 2'd3) begin
                            out_valid <= 1'b0;
                            pair_idx  <= 2'd0;
                            state     <= FILL;
                        end else begin
                            x1_r     <= mem_r[upper_addr(next_pair)];
                            x1_i     <= mem_i[upper_addr(next_pair)];
                            x2_r     <= mem_r[lower_addr(next_pair)];
                            x2_i     <= mem_i[lower_addr(next_pair)];
                            pair_idx <= next_pair;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_input_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft8_input_reorder
//
// Self-checking bench for fft8_input_reorder. Accepted samples are collected
// into a frame; when the eighth is accepted the four expected operand pairs
// are pushed to a scoreboard queue and popped as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_fft8_input_reorder;

    typedef struct {
        logic [15:0] x1r;
        logic [15:0] x1i;
        logic [15:0] x2r;
        logic [15:0] x2i;
        int          idx;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_r = '0;
    logic [15:0] in_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] x1_r;
    logic [15:0] x1_i;
    logic [15:0] x2_r;
    logic [15:0] x2_i;
    logic [1:0]  pair_idx;
    logic        frame_done;

    int          test_cnt = 0;
    int          fail_cnt = 0;
    int          hs_cnt = 0;
    bit          last_in_hs = 0;
    bit          prep_pending = 0;
    pair_t       exp_q [$];
    logic [15:0] fr_r [$];
    logic [15:0] fr_i [$];
    logic [15:0] src_r [8];
    logic [15:0] src_i [8];
    int          upper_map [4] = '{0, 2, 1, 3};
    logic        ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    fft8_input_reorder #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_i       (in_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x1_r       (x1_r),
        .x1_i       (x1_i),
        .x2_r       (x2_r),
        .x2_i       (x2_i),
        .pair_idx   (pair_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called just after a rising edge with inputs already
    // driven; observes on the falling edge, updates the scoreboard, then
    // advances past the next rising edge.
    task automatic cycle();
        pair_t f;
        bit    exp_rdy;
        bit    exp_fd;
        @(negedge clk);
        exp_rdy = (exp_q.size() == 0);
        exp_fd  = 1'b0;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0) && !prep_pending});
        if (out_valid && exp_q.size() != 0) begin
            f = exp_q[0];
            check("x1_r", {16'd0, x1_r}, {16'd0, f.x1r});
            check("x1_i", {16'd0, x1_i}, {16'd0, f.x1i});
            check("x2_r", {16'd0, x2_r}, {16'd0, f.x2r});
            check("x2_i", {16'd0, x2_i}, {16'd0, f.x2i});
            check("pair_idx", {30'd0, pair_idx}, f.idx);
            if (out_ready && f.idx == 3) exp_fd = 1'b1;
            if (out_ready) begin
                void'(exp_q.pop_front());
                hs_cnt++;
            end
        end
        check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        prep_pending = 1'b0;
        last_in_hs = in_valid && exp_rdy;
        if (last_in_hs) begin
            fr_r.push_back(in_r);
            fr_i.push_back(in_i);
            if (fr_r.size() == 8) begin
                for (int p = 0; p < 4; p++) begin
                    f.x1r = fr_r[upper_map[p]];
                    f.x1i = fr_i[upper_map[p]];
                    f.x2r = fr_r[upper_map[p] + 4];
                    f.x2i = fr_i[upper_map[p] + 4];
                    f.idx = p;
                    exp_q.push_back(f);
                end
                fr_r.delete();
                fr_i.delete();
                prep_pending = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Feeds nsamp samples from src_r/src_i; with gaps set, every third
    // cycle drops in_valid and drives junk data that must not be stored.
    task automatic apply_stimulus(input bit gaps, input int nsamp);
        int acc = 0;
        int n   = 0;
        while (acc < nsamp && n < 64) begin
            if (gaps && (n % 3 == 1)) begin
                in_valid = 1'b0;
                in_r     = 16'h5555;
                in_i     = 16'h5555;
            end else begin
                in_valid = 1'b1;
                in_r     = src_r[acc];
                in_i     = src_i[acc];
            end
            cycle();
            if (last_in_hs) acc++;
            n++;
        end
        check("fill_count", acc, nsamp);
        in_valid = 1'b0;
    endtask

    // Drains the pending frame, optionally shaping out_ready with the
    // stall pattern and optionally holding in_valid high with junk (-1).
    task automatic check_output(input bit use_pat, input bit hold_valid);
        int start = hs_cnt;
        int n     = 0;
        in_valid = hold_valid;
        in_r     = 16'hFFFF;
        in_i     = 16'hFFFF;
        while (exp_q.size() != 0 && n < 50) begin
            out_ready = (use_pat && n < 7) ? ready_pat[n] : 1'b1;
            cycle();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("handshakes", hs_cnt - start, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_pair_idx", {30'd0, pair_idx}, 0);
        check("rst_x", {x1_r, x1_i}, 0);
        check("rst_x2", {x2_r, x2_i}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        exp_q.delete();
        fr_r.delete();
        fr_i.delete();
        prep_pending = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then a few idle cycles.
        #2;
        do_reset();
        for (int k = 0; k < 3; k++) cycle();

        // Ramp frame with out_ready held high.
        for (int k = 0; k < 8; k++) begin
            src_r[k] = 16'(k);
            src_i[k] = 16'(10 * k);
        end
        apply_stimulus(1'b0, 8);
        check_output(1'b0, 1'b0);
        cycle();

        // Same frame with a stalling consumer.
        apply_stimulus(1'b0, 8);
        check_output(1'b1, 1'b0);

        // Gapped input, then junk held on in_valid throughout the drain.
        for (int k = 0; k < 8; k++) begin
            src_r[k] = 16'(100 + 3 * k);
            src_i[k] = 16'(16'hF000 + k);
        end
        apply_stimulus(1'b1, 8);
        check_output(1'b0, 1'b1);
        cycle();

        // Extreme values alternate between the two ends of the range.
        for (int k = 0; k < 8; k++) begin
            src_r[k] = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
            src_i[k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
        end
        apply_stimulus(1'b0, 8);
        check_output(1'b0, 1'b0);

        // Reset after five samples, then a complete frame.
        for (int k = 0; k < 8; k++) begin
            src_r[k] = 16'(16'h1230 + k);
            src_i[k] = 16'(16'hA000 - k);
        end
        apply_stimulus(1'b0, 5);
        do_reset();
        apply_stimulus(1'b0, 8);
        check_output(1'b0, 1'b0);

        // Reset while pair 2 is presented, then a complete frame.
        apply_stimulus(1'b0, 8);
        begin
            int n = 0;
            while (n < 20 && !(exp_q.size() != 0 && exp_q[0].idx == 2 && !prep_pending)) begin
                cycle();
                n++;
            end
            check("reach_pair2", {30'd0, pair_idx}, 2);
        end
        do_reset();
        for (int k = 0; k < 8; k++) begin
            src_r[k] = 16'(16'h0F00 + 16 * k);
            src_i[k] = 16'(16'h00F0 - k);
        end
        apply_stimulus(1'b0, 8);
        check_output(1'b0, 1'b0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
